// File: rtl/pixel_arb_pkg.sv
// Shared types and helpers for the frame-buffer write arbiter.
//   arb_state_t : arbiter ownership state (IDLE / OWN)
//   MODE_SEL    : winner chosen by the ENG_SEL input
//   MODE_RR     : winner chosen round-robin starting from the pointer
//   IDX_W()     : width of an engine index for a given engine count
package pixel_arb_pkg;

  typedef enum logic {IDLE, OWN} arb_state_t;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Never returns 0 so a 1-engine build still has a legal index vector.
  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_picker.sv
// Combinational rotate-priority encoder.
//   req   : per-engine request vector
//   ptr   : engine that gets highest priority (always < N_ENG)
//   valid : at least one engine is requesting
//   idx   : first requester found scanning ptr, ptr+1, ... mod N_ENG
module rr_picker
  import pixel_arb_pkg::*;
#(
  parameter int N_ENG = 4
) (
  input  logic [N_ENG-1:0]        req,
  input  logic [IDX_W(N_ENG)-1:0] ptr,
  output logic                    valid,
  output logic [IDX_W(N_ENG)-1:0] idx
);

  localparam int IW = IDX_W(N_ENG);

  int cand;

  // Explicit wrap instead of a modulo keeps non-power-of-two counts correct.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < N_ENG; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_ENG) cand = cand - N_ENG;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Frame-buffer write arbiter: N drawing engines share one write port using a
// registered request/grant handshake with burst ownership.
//   Clk, Reset          : clock, synchronous active-high reset
//   ENG_SEL             : engine to serve in select-driven mode
//   REQ / LAST          : per-engine beat valid / last beat of burst
//   PIXEL_DIN/X/Y       : packed per-engine beat payload
//   FB_BUSY             : frame buffer stalls this cycle
//   GNT                 : registered one-hot grant
//   ENG_PIXEL_DOUT/X/Y  : registered beat to the frame buffer
//   ENG_WE              : one-cycle strobe per accepted beat
//   ACTIVE_IDX          : current owner (0 when idle)
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int N_ENG   = 4,
  parameter int DATA_W  = 8,
  parameter int COORD_W = 9,
  parameter int MODE    = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [$clog2(N_ENG)-1:0]   ENG_SEL,
  input  logic [N_ENG-1:0]           REQ,
  input  logic [N_ENG-1:0]           LAST,
  input  logic [N_ENG*DATA_W-1:0]    PIXEL_DIN,
  input  logic [N_ENG*COORD_W-1:0]   PIXEL_X,
  input  logic [N_ENG*COORD_W-1:0]   PIXEL_Y,
  input  logic                       FB_BUSY,
  output logic [N_ENG-1:0]           GNT,
  output logic [DATA_W-1:0]          ENG_PIXEL_DOUT,
  output logic [COORD_W-1:0]         ENG_PIXEL_X,
  output logic [COORD_W-1:0]         ENG_PIXEL_Y,
  output logic                       ENG_WE,
  output logic [$clog2(N_ENG)-1:0]   ACTIVE_IDX
);

  localparam int IW = IDX_W(N_ENG);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      act_q, act_d;
  logic [N_ENG-1:0]   gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  logic               rr_vld;
  logic [IW-1:0]      rr_idx;
  logic               sel_hit;
  logic               win_vld;
  logic [IW-1:0]      win_idx;
  logic               beat_ok;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == N_ENG - 1) ? '0 : i + 1'b1;
  endfunction

  rr_picker #(.N_ENG(N_ENG)) u_rr_picker (
    .req   (REQ),
    .ptr   (ptr_q),
    .valid (rr_vld),
    .idx   (rr_idx)
  );

  // An out-of-range ENG_SEL matches no engine and so never produces a grant.
  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < N_ENG; i++) begin
      if (ENG_SEL == IW'(i) && REQ[i]) sel_hit = 1'b1;
    end
  end

  always_comb begin
    win_vld = (MODE == MODE_SEL) ? sel_hit : rr_vld;
    win_idx = (MODE == MODE_SEL) ? ENG_SEL : rr_idx;
    beat_ok = REQ[act_q] && !FB_BUSY;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    act_d   = act_q;
    gnt_d   = gnt_q;
    we_d    = 1'b0;
    dout_d  = dout_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d          = OWN;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          act_d            = win_idx;
        end
      end
      OWN: begin
        // Other engines and ENG_SEL are deliberately ignored while owned.
        if (beat_ok) begin
          we_d   = 1'b1;
          dout_d = PIXEL_DIN[int'(act_q)*DATA_W +: DATA_W];
          x_d    = PIXEL_X[int'(act_q)*COORD_W +: COORD_W];
          y_d    = PIXEL_Y[int'(act_q)*COORD_W +: COORD_W];
          if (LAST[act_q]) begin
            // Returning through IDLE forces a one-cycle gap between owners.
            state_d = IDLE;
            gnt_d   = '0;
            act_d   = '0;
            ptr_d   = next_idx(act_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      act_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      act_q   <= act_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign GNT            = gnt_q;
  assign ENG_PIXEL_DOUT = dout_q;
  assign ENG_PIXEL_X    = x_q;
  assign ENG_PIXEL_Y    = y_q;
  assign ENG_WE         = we_q;
  assign ACTIVE_IDX     = act_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: three instances (4 engines round-robin,
// 4 engines select-driven, 5 engines select-driven) share clock, reset,
// FB_BUSY and the per-engine payload arrays; each is tracked by a
// transaction-level reference model.
module tb_pixel_write_arbiter;

  logic       Clk;
  logic       rst;
  logic       busy;
  logic [1:0] sel4;
  logic [3:0] req4, last4;
  logic [2:0] sel5;
  logic [4:0] req5, last5;

  logic [7:0] din_a [8];
  logic [8:0] x_a   [8];
  logic [8:0] y_a   [8];

  logic [31:0] din_p4;
  logic [35:0] x_p4, y_p4;
  logic [39:0] din_p5;
  logic [44:0] x_p5, y_p5;

  always_comb begin
    din_p4 = '0; x_p4 = '0; y_p4 = '0;
    din_p5 = '0; x_p5 = '0; y_p5 = '0;
    for (int i = 0; i < 4; i++) begin
      din_p4[i*8 +: 8] = din_a[i];
      x_p4[i*9 +: 9]   = x_a[i];
      y_p4[i*9 +: 9]   = y_a[i];
    end
    for (int i = 0; i < 5; i++) begin
      din_p5[i*8 +: 8] = din_a[i];
      x_p5[i*9 +: 9]   = x_a[i];
      y_p5[i*9 +: 9]   = y_a[i];
    end
  end

  logic [3:0] gnt_rr, gnt_sel;
  logic [4:0] gnt_5;
  logic [7:0] dout_rr, dout_sel, dout_5;
  logic [8:0] x_rr, x_sel, x_5, y_rr, y_sel, y_5;
  logic       we_rr, we_sel, we_5;
  logic [1:0] act_rr, act_sel;
  logic [2:0] act_5;

  pixel_write_arbiter #(.N_ENG(4), .DATA_W(8), .COORD_W(9), .MODE(1)) u_rr (
    .Clk(Clk), .Reset(rst), .ENG_SEL(sel4), .REQ(req4), .LAST(last4),
    .PIXEL_DIN(din_p4), .PIXEL_X(x_p4), .PIXEL_Y(y_p4), .FB_BUSY(busy),
    .GNT(gnt_rr), .ENG_PIXEL_DOUT(dout_rr), .ENG_PIXEL_X(x_rr),
    .ENG_PIXEL_Y(y_rr), .ENG_WE(we_rr), .ACTIVE_IDX(act_rr));

  pixel_write_arbiter #(.N_ENG(4), .DATA_W(8), .COORD_W(9), .MODE(0)) u_sel (
    .Clk(Clk), .Reset(rst), .ENG_SEL(sel4), .REQ(req4), .LAST(last4),
    .PIXEL_DIN(din_p4), .PIXEL_X(x_p4), .PIXEL_Y(y_p4), .FB_BUSY(busy),
    .GNT(gnt_sel), .ENG_PIXEL_DOUT(dout_sel), .ENG_PIXEL_X(x_sel),
    .ENG_PIXEL_Y(y_sel), .ENG_WE(we_sel), .ACTIVE_IDX(act_sel));

  pixel_write_arbiter #(.N_ENG(5), .DATA_W(8), .COORD_W(9), .MODE(0)) u_5 (
    .Clk(Clk), .Reset(rst), .ENG_SEL(sel5), .REQ(req5), .LAST(last5),
    .PIXEL_DIN(din_p5), .PIXEL_X(x_p5), .PIXEL_Y(y_p5), .FB_BUSY(busy),
    .GNT(gnt_5), .ENG_PIXEL_DOUT(dout_5), .ENG_PIXEL_X(x_5),
    .ENG_PIXEL_Y(y_5), .ENG_WE(we_5), .ACTIVE_IDX(act_5));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner is -1 when nobody holds the port.
  typedef struct {
    int owner; int ptr; int gnt; int we; int dout; int x; int y; int act;
  } mdl_t;

  mdl_t m_rr, m_sel, m_5;

  function automatic mdl_t mdl_next(mdl_t m, int n, int mode, int sel,
                                    int req, int last);
    mdl_t r;
    int win, c, i;
    r = m;
    r.we = 0;
    if (rst) begin
      r.owner = -1; r.ptr = 0; r.gnt = 0; r.dout = 0;
      r.x = 0; r.y = 0; r.act = 0;
      return r;
    end
    if (m.owner < 0) begin
      win = -1;
      if (mode == 0) begin
        if (sel < n && ((req >> sel) & 1) == 1) win = sel;
      end else begin
        for (int k = 0; k < n; k++) begin
          c = (m.ptr + k) % n;
          if (win < 0 && ((req >> c) & 1) == 1) win = c;
        end
      end
      if (win >= 0) begin
        r.owner = win; r.gnt = 1 << win; r.act = win;
      end
    end else begin
      i = m.owner;
      if (((req >> i) & 1) == 1 && !busy) begin
        r.we = 1;
        r.dout = int'(din_a[i]); r.x = int'(x_a[i]); r.y = int'(y_a[i]);
        if (((last >> i) & 1) == 1) begin
          r.owner = -1; r.gnt = 0; r.act = 0; r.ptr = (i + 1) % n;
        end
      end
    end
    return r;
  endfunction

  task automatic cmp(input string tag, input mdl_t m, input int g, input int w,
                     input int d, input int x, input int y, input int a);
    chk({tag, "_gnt"},  g, m.gnt);
    chk({tag, "_we"},   w, m.we);
    chk({tag, "_dout"}, d, m.dout);
    chk({tag, "_x"},    x, m.x);
    chk({tag, "_y"},    y, m.y);
    chk({tag, "_act"},  a, m.act);
  endtask

  // One clock: predict from the current inputs, clock, then compare all DUTs.
  task automatic cycle();
    mdl_t n_rr, n_sel, n_5;
    n_rr  = mdl_next(m_rr, 4, 1, int'(sel4), int'(req4), int'(last4));
    n_sel = mdl_next(m_sel, 4, 0, int'(sel4), int'(req4), int'(last4));
    n_5   = mdl_next(m_5, 5, 0, int'(sel5), int'(req5), int'(last5));
    @(posedge Clk);
    #1;
    m_rr = n_rr; m_sel = n_sel; m_5 = n_5;
    cmp("rr",  m_rr,  int'(gnt_rr),  int'(we_rr),  int'(dout_rr),  int'(x_rr),  int'(y_rr),  int'(act_rr));
    cmp("sel", m_sel, int'(gnt_sel), int'(we_sel), int'(dout_sel), int'(x_sel), int'(y_sel), int'(act_sel));
    cmp("n5",  m_5,   int'(gnt_5),   int'(we_5),   int'(dout_5),   int'(x_5),   int'(y_5),   int'(act_5));
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    int         exp_gnt;
    int         exp_we;
    int         exp_act;
    int         exp_dout;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Round-robin with every engine requesting single-beat bursts.
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 0, 0, 0, 'h00};
    tbl[1]  = '{1'b0, 4'hF, 4'hF, 1, 0, 0, 'h00};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 0, 1, 0, 'h10};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 2, 0, 1, 'h10};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 0, 1, 0, 'h11};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 4, 0, 2, 'h11};
    tbl[6]  = '{1'b0, 4'hF, 4'hF, 0, 1, 0, 'h12};
    tbl[7]  = '{1'b0, 4'hF, 4'hF, 8, 0, 3, 'h12};
    tbl[8]  = '{1'b0, 4'hF, 4'hF, 0, 1, 0, 'h13};
    tbl[9]  = '{1'b0, 4'hF, 4'hF, 1, 0, 0, 'h13};
    tbl[10] = '{1'b0, 4'hF, 4'hF, 0, 1, 0, 'h10};

    rst = 1'b1; busy = 1'b0; sel4 = 2'd0; req4 = '0; last4 = '0;
    sel5 = 3'd6; req5 = 5'h1F; last5 = 5'h1F;
    for (int i = 0; i < 8; i++) begin
      din_a[i] = 8'(8'h10 + i); x_a[i] = 9'(i); y_a[i] = 9'(2 * i);
    end
    m_rr = '{-1, 0, 0, 0, 0, 0, 0, 0}; m_sel = m_rr; m_5 = m_rr;

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; req4 = tbl[i].req; last4 = tbl[i].last;
      cycle();
      chk($sformatf("tbl%0d_gnt", i),  int'(gnt_rr),  tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_we", i),   int'(we_rr),   tbl[i].exp_we);
      chk($sformatf("tbl%0d_act", i),  int'(act_rr),  tbl[i].exp_act);
      chk($sformatf("tbl%0d_dout", i), int'(dout_rr), tbl[i].exp_dout);
    end

    // Engine 2 three-beat burst with engine 0 waiting and a 2-cycle stall.
    req4 = 4'b0101; last4 = 4'b0000;
    din_a[2] = 8'h3C; x_a[2] = 9'd10; y_a[2] = 9'd5;
    cycle();
    chk("burst_gnt", int'(gnt_rr), 4);
    cycle();
    chk("beat1_we", int'(we_rr), 1); chk("beat1_x", int'(x_rr), 10);
    chk("beat1_y", int'(y_rr), 5);   chk("beat1_dout", int'(dout_rr), 'h3C);
    x_a[2] = 9'd11;
    cycle();
    chk("beat2_we", int'(we_rr), 1); chk("beat2_x", int'(x_rr), 11);
    busy = 1'b1; x_a[2] = 9'd12;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("stall_we", int'(we_rr), 0); chk("stall_x", int'(x_rr), 11);
    end
    busy = 1'b0; last4 = 4'b0100;
    cycle();
    chk("beat3_we", int'(we_rr), 1); chk("beat3_x", int'(x_rr), 12);
    chk("beat3_gnt", int'(gnt_rr), 0);
    req4 = 4'b0001; last4 = 4'b0000;
    cycle();
    chk("after_last_gnt", int'(gnt_rr), 1);
    last4 = 4'b0001;
    cycle();
    req4 = '0; last4 = '0;
    cycle();

    // Select-driven: ENG_SEL change mid-burst is ignored.
    rst = 1'b1; cycle(); rst = 1'b0;
    sel4 = 2'd1; req4 = 4'b0011;
    cycle();
    chk("sel_gnt", int'(gnt_sel), 2);
    sel4 = 2'd0;
    cycle();
    chk("sel_hold_gnt", int'(gnt_sel), 2); chk("sel_hold_act", int'(act_sel), 1);
    chk("sel_hold_we", int'(we_sel), 1);
    last4 = 4'b0010;
    cycle();
    chk("sel_last_we", int'(we_sel), 1); chk("sel_last_gnt", int'(gnt_sel), 0);
    last4 = 4'b0000;
    cycle();
    chk("sel_next_gnt", int'(gnt_sel), 1);
    last4 = 4'b0001; cycle();
    req4 = '0; last4 = '0; cycle();

    // Reset during engine 3's second beat.
    rst = 1'b1; cycle(); rst = 1'b0;
    sel4 = 2'd3; req4 = 4'b1000;
    din_a[3] = 8'hA5; x_a[3] = 9'd77; y_a[3] = 9'd99;
    cycle();
    chk("e3_gnt", int'(gnt_rr), 8);
    cycle();
    chk("e3_beat1_we", int'(we_rr), 1);
    rst = 1'b1;
    cycle();
    chk("rst_gnt", int'(gnt_rr), 0);   chk("rst_we", int'(we_rr), 0);
    chk("rst_dout", int'(dout_rr), 0); chk("rst_x", int'(x_rr), 0);
    chk("rst_y", int'(y_rr), 0);       chk("rst_act", int'(act_rr), 0);
    rst = 1'b0;
    cycle();
    chk("rst_regrant", int'(gnt_rr), 8);
    last4 = 4'b1000; cycle();
    req4 = '0; last4 = '0; cycle();

    // Five engines, out-of-range select: never any grant.
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("oor_gnt", int'(gnt_5), 0); chk("oor_we", int'(we_5), 0);
    end
    sel5 = 3'd4;
    cycle();
    chk("sel5_top_gnt", int'(gnt_5), 16);
    cycle();
    chk("sel5_top_we", int'(we_5), 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      busy  = ($urandom_range(0, 3) == 0);
      req4  = 4'($urandom);
      last4 = 4'($urandom & $urandom);
      sel4  = 2'($urandom);
      req5  = 5'($urandom);
      last5 = 5'($urandom & $urandom);
      sel5  = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) begin
        din_a[i] = 8'($urandom);
        x_a[i]   = 9'($urandom_range(0, 511));
        y_a[i]   = 9'($urandom_range(0, 511));
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
